audio_serial_tx: RTL
====================

AUDIO_SERIAL_TX -- requirements
Module: audio_serial_tx

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 8: clk cycles per bclk half-period, legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: sample buffer entries, a power of two between 2 and 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port sample_valid, input, 1 bit: a sample is offered this cycle.
REQ-006 SHALL have port sample_in, input, 16 bits: signed two's-complement sample, i.e. the filter output_sample.
REQ-007 SHALL have port sample_ready, output, 1 bit: the buffer can accept a sample.
REQ-008 SHALL have port bclk, output, 1 bit: serial bit clock.
REQ-009 SHALL have port lrclk, output, 1 bit: word select, 0 = left, 1 = right.
REQ-010 SHALL have port sdata, output, 1 bit: serial data, MSB first, I2S format.
REQ-011 SHALL have port underrun, output, 1 bit: one-cycle pulse when a frame starts with the buffer empty.

Function
REQ-012 SHALL accept a sample on any clk edge where sample_valid=1 and sample_ready=1; the sample is written to the FIFO tail.
REQ-013 SHALL drive sample_ready = (registered count < FIFO_DEPTH).
- A pop in the same cycle SHALL NOT make a full FIFO accept a push.
REQ-014 SHALL use a divider counter running 0..BCLK_DIV-1; bclk toggles when the counter reaches its terminal count.
- bclk period = 2*BCLK_DIV clk cycles.
REQ-015 SHALL define the bclk falling edge (the registered 1->0 toggle) as the shift event.
- lrclk and sdata change only on the same clk edge as a shift event.
REQ-016 SHALL keep a 5-bit slot counter s that advances 0..31 at each shift event and wraps from 31 to 0.
- One frame = 32 slots = 64*BCLK_DIV clk cycles.
REQ-017 SHALL drive lrclk=1 for s in 15..30 and lrclk=0 for s in 31 and 0..14, so lrclk leads each word's MSB by one slot.
REQ-018 SHALL drive sdata = frame_word[15-s] for s in 0..15 (left) and sdata = frame_word[31-s] for s in 16..31 (right).
- Mono: the same word is sent on both channels.
REQ-019 SHALL, at the shift event entering s=0, handle the FIFO head as follows:
- FIFO non-empty: pop the head into frame_word.
- FIFO empty: load 16'h0000 and pulse underrun high for exactly one clk cycle.
REQ-020 SHALL treat a push and an underrun pop in the same cycle as follows:
- the pop sees the FIFO empty and underruns;
- the pushed sample is retained for the next frame.
REQ-021 SHALL treat simultaneous push and pop on a non-empty, non-full FIFO as count unchanged, preserving order.
REQ-022 SHALL never drop, duplicate or reorder accepted samples.
REQ-023 SHALL use FIFO pointers that wrap modulo FIFO_DEPTH.
REQ-024 SHALL drive frame_word unchanged for the whole frame; pushes mid-frame do not alter bits already scheduled.

Reset
REQ-025 SHALL, while rst_n=0, hold these values:
- bclk=0, lrclk=0, sdata=0, underrun=0, sample_ready=1;
- FIFO count 0, divider 0, slot counter 31, frame_word 16'h0000.
REQ-026 SHALL make the first shift event after reset release enter s=0 and perform the REQ-019 load.
REQ-027 SHALL, on reset asserted mid-frame, discard buffered samples and the partial frame immediately, with no glitch past reset values.

Verification
REQ-028 SHALL cover reset values: hold rst_n=0 for 5 cycles -> all outputs at REQ-025 values, sample_ready=1.
REQ-029 SHALL cover single-sample transmission: BCLK_DIV=2; push 16'hA5F0 before the first frame ->
- left slots 0..15 carry 1010010111110000;
- right slots 16..31 carry the same bits;
- lrclk toggles at s=15 and s=31;
- bclk period = 4 clk cycles.
REQ-030 SHALL cover underrun: no pushes for 3 frames -> sdata=0 throughout and exactly one underrun pulse per frame, at each s=0 entry.
REQ-031 SHALL cover back-pressure: FIFO_DEPTH=4; push 16'h0001..16'h0004 back-to-back ->
- sample_ready=0 after the 4th push;
- a 5th sample held valid is accepted only after the next frame pop;
- frames output 0001, 0002, 0003, 0004, then the 5th sample, in order.
REQ-032 SHALL cover push at frame boundary: push on the same cycle as the s=0 entry with the FIFO empty -> underrun pulses, and the sample appears in the following frame.
REQ-033 SHALL cover reset mid-frame: assert rst_n=0 at s=7 with 2 samples buffered -> outputs return to reset values asynchronously, and after release the next frame underruns (FIFO empty).

Source files
------------

// File: rtl/audio_serial_tx.sv
// ---------------------------------------------------------------------------
// audio_serial_tx
//
// Buffers 16-bit signed audio samples in a small FIFO and serialises them as
// an I2S mono stream.  Each 32-slot frame pops one sample from the buffer and
// sends it on both the left and the right channel, MSB first.  If no sample is
// buffered when a frame begins, the frame carries silence and a one-cycle
// underrun pulse is raised.
//
// Parameters
//   BCLK_DIV     clk cycles per bclk half-period (2..255)
//   FIFO_DEPTH   sample buffer entries (power of two, 2..16)
//
// Ports
//   clk          single clock; all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   sample_valid a sample is offered this cycle
//   sample_in    16-bit two's-complement sample
//   sample_ready buffer can accept a sample (registered count below depth)
//   bclk         serial bit clock, period 2*BCLK_DIV clk cycles
//   lrclk        word select, 0 = left, 1 = right
//   sdata        serial data, MSB first, I2S alignment
//   underrun     one-cycle pulse when a frame starts with the buffer empty
// ---------------------------------------------------------------------------
module audio_serial_tx #(
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [15:0] sample_in,
    output logic        sample_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DIV_W = $clog2(BCLK_DIV);

    logic [15:0]      fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic             bclk_q, bclk_d;
    logic [4:0]       slot_q, slot_d;
    logic [15:0]      frameWord_q, frameWord_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic             underrun_q, underrun_d;

    logic             divTerm;
    logic             shiftEvt;
    logic             frameStart;
    logic             fifoEmpty;
    logic             pushEn;
    logic             popEn;

    // Readiness comes from the registered count only, so a pop happening in
    // the same cycle never lets a full buffer take another sample.
    assign sample_ready = (count_q < CNT_W'(FIFO_DEPTH));

    // Next-state logic.  The shift event is the bclk 1->0 toggle; the slot
    // counter, lrclk and sdata only move on that edge.  Entering slot 0 is the
    // frame boundary where the buffer head is consumed.  The pop looks at the
    // registered count, so a push landing on the boundary of an empty buffer
    // still underruns and the pushed sample waits for the next frame.
    always_comb begin
        divTerm     = (divCnt_q == DIV_W'(BCLK_DIV - 1));
        shiftEvt    = divTerm && bclk_q;
        frameStart  = shiftEvt && (slot_q == 5'd31);
        fifoEmpty   = (count_q == '0);
        pushEn      = sample_valid && sample_ready;
        popEn       = frameStart && !fifoEmpty;

        divCnt_d    = divTerm ? '0 : divCnt_q + DIV_W'(1);
        bclk_d      = divTerm ? ~bclk_q : bclk_q;
        slot_d      = shiftEvt ? slot_q + 5'd1 : slot_q;

        frameWord_d = frameWord_q;
        if (frameStart) begin
            frameWord_d = fifoEmpty ? 16'h0000 : fifoMem_q[rdPtr_q];
        end

        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        if (shiftEvt) begin
            // lrclk switches one slot ahead of each word's MSB.
            lrclk_d = (slot_d >= 5'd15) && (slot_d <= 5'd30);
            // Slot s carries bit 15-s on the left and 31-s on the right; both
            // reduce to the inverted low nibble of the slot number.
            sdata_d = frameWord_d[~slot_d[3:0]];
        end

        underrun_d = frameStart && fifoEmpty;

        wrPtr_d = pushEn ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = popEn  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d = count_q + CNT_W'(pushEn) - CNT_W'(popEn);
    end

    // Sample storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            fifoMem_q[wrPtr_q] <= sample_in;
        end
    end

    // Control and output registers.  Slot starts at 31 so the first shift
    // event after reset enters slot 0 and loads a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            divCnt_q    <= '0;
            bclk_q      <= 1'b0;
            slot_q      <= 5'd31;
            frameWord_q <= 16'h0000;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            divCnt_q    <= divCnt_d;
            bclk_q      <= bclk_d;
            slot_q      <= slot_d;
            frameWord_q <= frameWord_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

endmodule
